// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared types and constants for the gate keypad front end
package gate_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PRESENT = 2'd2
    } state_t;

    localparam int KEY_W          = 4;
    localparam int DEFAULT_DIGITS = 2;

endpackage

// File: rtl/keypad_entry_if.sv
// rtl/keypad_entry_if.sv - keypad strobes in, presented password word out
interface keypad_entry_if #(
    parameter int DIGITS = gate_pkg::DEFAULT_DIGITS
);
    import gate_pkg::*;

    logic                           asensor;
    logic                           key_valid;
    logic [KEY_W-1:0]               key_digit;
    logic                           key_enter;
    logic                           key_clear;
    logic [KEY_W*DIGITS-1:0]        password;
    logic                           pw_valid;
    logic                           entry_err;
    logic [$clog2(DIGITS+1)-1:0]    digit_count;
    logic                           timeout;

    modport master (
        output asensor, key_valid, key_digit, key_enter, key_clear,
        input  password, pw_valid, entry_err, digit_count, timeout
    );

    modport slave (
        input  asensor, key_valid, key_digit, key_enter, key_clear,
        output password, pw_valid, entry_err, digit_count, timeout
    );

endinterface

// File: rtl/entry_timer.sv
// rtl/entry_timer.sv - inactivity counter for a partly entered code
module entry_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_clear,
    output logic o_expire
);
    localparam int T_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [T_W-1:0] LAST = T_W'(TIMEOUT_CYCLES - 1);

    logic [T_W-1:0] r_cnt;

    // Counts only while nothing holds it at zero; a key event restarts the wait.
    always_ff @(posedge clk) begin
        if (rst || i_load || i_clear) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + T_W'(1);
        end
    end

    assign o_expire = !i_clear && (r_cnt == LAST);

endmodule

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - hex keypad collector; optional inactivity timeout under KEYPAD_TIMEOUT_EN
module keypad_entry
    import gate_pkg::*;
#(
    parameter int DIGITS         = DEFAULT_DIGITS,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic            clk,
    input  logic            rst,
    keypad_entry_if.slave   kif
);
    localparam int PW_W  = KEY_W * DIGITS;
    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DIGITS);

    state_t              r_state,     w_state_nx;
    logic [PW_W-1:0]     r_buf,       w_buf_nx;
    logic [PW_W-1:0]     r_pw,        w_pw_nx;
    logic [CNT_W-1:0]    r_cnt,       w_cnt_nx;
    logic                r_pw_valid,  w_pw_valid_nx;
    logic                r_entry_err, w_entry_err_nx;
    logic                r_timeout,   w_timeout_nx;
    logic                w_expire;

`ifdef KEYPAD_TIMEOUT_EN
    logic w_key_event;
    logic w_timer_clear;

    assign w_key_event   = kif.key_valid | kif.key_enter | kif.key_clear;
    assign w_timer_clear = (r_state != COLLECT) || (r_cnt == '0) || !kif.asensor;

    entry_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_entry_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_key_event | w_expire),
        .i_clear  (w_timer_clear),
        .o_expire (w_expire)
    );
`else
    wire w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign w_expire = 1'b0;
`endif

    always_comb begin
        w_state_nx     = r_state;
        w_buf_nx       = r_buf;
        w_pw_nx        = r_pw;
        w_cnt_nx       = r_cnt;
        w_pw_valid_nx  = 1'b0;
        w_entry_err_nx = 1'b0;
        w_timeout_nx   = 1'b0;

        if (r_state == IDLE) begin
            if (kif.asensor) begin
                w_state_nx = COLLECT;
                w_buf_nx   = '0;
                w_cnt_nx   = '0;
            end
        end else if (!kif.asensor) begin
            // Vehicle left: withdraw the code and drop any simultaneous key.
            w_state_nx = IDLE;
            w_pw_nx    = '0;
            w_buf_nx   = '0;
            w_cnt_nx   = '0;
        end else if (kif.key_clear) begin
            w_buf_nx = '0;
            w_cnt_nx = '0;
        end else if (kif.key_enter) begin
            w_buf_nx = '0;
            w_cnt_nx = '0;
            if (r_cnt == FULL) begin
                w_pw_nx       = r_buf;
                w_pw_valid_nx = 1'b1;
                w_state_nx    = PRESENT;
            end else begin
                w_entry_err_nx = 1'b1;
            end
        end else if (kif.key_valid) begin
            w_state_nx = COLLECT;
            if (r_cnt < FULL) begin
                w_buf_nx = {r_buf[PW_W-KEY_W-1:0], kif.key_digit};
                w_cnt_nx = r_cnt + CNT_W'(1);
            end
        end else if (w_expire) begin
            w_buf_nx     = '0;
            w_cnt_nx     = '0;
            w_timeout_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_buf       <= '0;
            r_pw        <= '0;
            r_cnt       <= '0;
            r_pw_valid  <= 1'b0;
            r_entry_err <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_buf       <= w_buf_nx;
            r_pw        <= w_pw_nx;
            r_cnt       <= w_cnt_nx;
            r_pw_valid  <= w_pw_valid_nx;
            r_entry_err <= w_entry_err_nx;
            r_timeout   <= w_timeout_nx;
        end
    end

    assign kif.password    = r_pw;
    assign kif.pw_valid    = r_pw_valid;
    assign kif.entry_err   = r_entry_err;
    assign kif.digit_count = r_cnt;
    assign kif.timeout     = r_timeout;

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - directed and random keypad traffic against a queue-based model
module tb_keypad_entry;

    localparam int D = 2;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    keypad_entry_if #(.DIGITS(D)) kif ();

    keypad_entry #(
        .DIGITS         (D),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    bit          m_active  = 1'b0;
    bit          m_present = 1'b0;
    int          m_digits[$];
    int unsigned m_pw      = 0;
    int          m_idle    = 0;
    bit          m_pv      = 1'b0;
    bit          m_ee      = 1'b0;
    bit          m_to      = 1'b0;

    function automatic bit timeout_enabled();
`ifdef KEYPAD_TIMEOUT_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step(input bit r, input bit a, input bit kv, input int kd,
                              input bit ke, input bit kc);
        int unsigned v;
        m_pv = 1'b0;
        m_ee = 1'b0;
        m_to = 1'b0;
        if (r) begin
            m_active = 1'b0; m_present = 1'b0; m_digits.delete(); m_pw = 0; m_idle = 0;
        end else if (!m_active) begin
            if (a) begin
                m_active = 1'b1; m_present = 1'b0; m_digits.delete(); m_idle = 0;
            end
        end else if (!a) begin
            m_active = 1'b0; m_present = 1'b0; m_digits.delete(); m_pw = 0; m_idle = 0;
        end else if (kc) begin
            m_digits.delete(); m_idle = 0;
        end else if (ke) begin
            if (m_digits.size() == D) begin
                v = 0;
                foreach (m_digits[i]) v = v * 16 + m_digits[i];
                m_pw = v; m_pv = 1'b1; m_present = 1'b1;
            end else begin
                m_ee = 1'b1;
            end
            m_digits.delete(); m_idle = 0;
        end else if (kv) begin
            if (m_digits.size() < D) m_digits.push_back(kd);
            m_present = 1'b0; m_idle = 0;
        end else if (timeout_enabled() && !m_present && m_digits.size() > 0) begin
            m_idle++;
            if (m_idle == T) begin
                m_digits.delete(); m_to = 1'b1; m_idle = 0;
            end
        end else begin
            m_idle = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input bit r, input bit a, input bit kv, input bit [3:0] kd,
                        input bit ke, input bit kc);
        rst           = r;
        kif.asensor   = a;
        kif.key_valid = kv;
        kif.key_digit = kd;
        kif.key_enter = ke;
        kif.key_clear = kc;
        @(posedge clk);
        model_step(r, a, kv, int'(kd), ke, kc);
        #1;
        chk("password",    32'(kif.password),    m_pw);
        chk("pw_valid",    32'(kif.pw_valid),    32'(m_pv));
        chk("entry_err",   32'(kif.entry_err),   32'(m_ee));
        chk("timeout",     32'(kif.timeout),     32'(m_to));
        chk("digit_count", 32'(kif.digit_count), 32'(m_digits.size()));
    endtask

    task automatic key(input bit [3:0] d);  tick(0, 1, 1, d, 0, 0); endtask
    task automatic enter();                 tick(0, 1, 0, 0, 1, 0); endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        bit a_cur;

        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        chk("reset_password", 32'(kif.password), 32'h0);

        // Basic entry and withdraw
        idle(1); key(4'h2); key(4'hA); enter();
        chk("t1_pw_2a", 32'(kif.password), 32'h2A);
        idle(2);
        tick(0, 0, 0, 0, 0, 0);
        chk("t1_pw_zero", 32'(kif.password), 32'h0);

        // Incomplete enter, then successive codes
        idle(1); key(4'h2); enter();
        key(4'h2); key(4'hE); enter(); idle(3);
        chk("t2_pw_2e", 32'(kif.password), 32'h2E);
        key(4'hA); idle(2); key(4'hA); enter(); idle(2);
        enter();

        // Overflow digit dropped, clear beats digit, clear in PRESENT
        key(4'h2); key(4'hA); key(4'hF); enter();
        tick(0, 1, 1, 4'h1, 0, 1);
        chk("t3_pw_held", 32'(kif.password), 32'h2A);
        key(4'h3); tick(0, 1, 0, 0, 0, 1); enter();

        // Keys while absent; sensor drop in the same cycle as a good enter
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 4'h5, 0, 0); tick(0, 0, 0, 0, 1, 0); tick(0, 0, 0, 0, 0, 1);
        idle(1); key(4'h2); key(4'hA);
        tick(0, 0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 0, 0);

        // Inactivity: one long gap, then keys every 10 cycles
        idle(1); key(4'h7); idle(T + 2);
        key(4'h1); idle(9); key(4'h2); idle(9); tick(0, 1, 0, 0, 0, 1); idle(9);
        key(4'h3); idle(9); key(4'h4); idle(9);
        enter(); key(4'h6); idle(T - 2); key(4'h6); idle(3);

        // Reset mid-entry and while presenting
        key(4'h9);
        tick(1, 1, 0, 0, 0, 0);
        idle(1); key(4'h2); key(4'hA); enter(); idle(1);
        tick(1, 1, 0, 0, 0, 0);
        idle(2);

        a_cur = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            bit r, kv, ke, kc;
            if ($urandom_range(0, 79) == 0) a_cur = ~a_cur;
            r  = ($urandom_range(0, 299) == 0);
            kv = ($urandom_range(0, 5) == 0);
            ke = ($urandom_range(0, 9) == 0);
            kc = ($urandom_range(0, 39) == 0);
            tick(r, a_cur, kv, 4'($urandom_range(0, 15)), ke, kc);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
